// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned DEF_REG_ADDR_W = 5;

    // Scoreboard slot indices, youngest first.
    localparam int unsigned SB_DEPTH = 3;
    localparam int unsigned SB_EX    = 0;
    localparam int unsigned SB_MEM   = 1;
    localparam int unsigned SB_WB    = 2;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic                      v;
        logic [DEF_REG_ADDR_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry shift register of in-flight register writes (EX, MEM, WB) with
// per-entry source-register match outputs.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_v,
    input  logic [DEF_REG_ADDR_W-1:0] push_rd,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [DEF_REG_ADDR_W-1:0] rs1,
    input  logic [DEF_REG_ADDR_W-1:0] rs2,
    output logic [SB_DEPTH-1:0]       rs1_match,
    output logic [SB_DEPTH-1:0]       rs2_match
);

    sb_entry_t [SB_DEPTH-1:0] sb_q;
    sb_entry_t [SB_DEPTH-1:0] sb_d;

    // The WB slot always inherits MEM: a flush only kills the two younger slots.
    always_comb begin
        sb_d[SB_WB]  = sb_q[SB_MEM];
        sb_d[SB_MEM] = flush ? '0 : sb_q[SB_EX];
        sb_d[SB_EX]  = '0;
        if (!stall && !flush) begin
            sb_d[SB_EX].v  = push_v;
            sb_d[SB_EX].rd = push_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    always_comb begin
        rs1_match = '0;
        rs2_match = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            rs1_match[i] = sb_q[i].v && (sb_q[i].rd == rs1);
            rs2_match[i] = sb_q[i].v && (sb_q[i].rd == rs2);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stall / taken-branch flush priority, FSM and
// saturating event counters. Define HAZARD_WB_BYPASS_EN for a write-through RF.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rf_we,
    input  logic                  mem_pc_src,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            hz_state,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

`ifdef HAZARD_WB_BYPASS_EN
    // Write-through RF: a producer in WB is already visible to ID.
    localparam logic [SB_DEPTH-1:0] CHK_MASK = 3'b011;
`else
    localparam logic [SB_DEPTH-1:0] CHK_MASK = 3'b111;
`endif

    logic [SB_DEPTH-1:0] rs1_match;
    logic [SB_DEPTH-1:0] rs2_match;
    logic                rs1_hit;
    logic                rs2_hit;
    logic                hazard;
    logic                flush;
    logic                push_v;

    hz_state_t        state_q;
    hz_state_t        state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    assign push_v  = id_valid && id_rf_we && (id_rd != '0);
    assign rs1_hit = id_use_rs1 && (id_rs1 != '0) && |(rs1_match & CHK_MASK);
    assign rs2_hit = id_use_rs2 && (id_rs2 != '0) && |(rs2_match & CHK_MASK);
    assign flush   = mem_pc_src;
    // Already excludes flush cycles, so it doubles as the stall strobe.
    assign hazard  = id_valid && !mem_pc_src && (rs1_hit || rs2_hit);

    hazard_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_v    (push_v),
        .push_rd   (id_rd),
        .stall     (hazard),
        .flush     (flush),
        .rs1       (id_rs1),
        .rs2       (id_rs2),
        .rs1_match (rs1_match),
        .rs2_match (rs2_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = StRun;
        if (flush) begin
            state_d = StFlush;
        end else if (hazard) begin
            state_d = StStall;
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (flush) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    assign hz_state    = state_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
